// File: rtl/buck_dpwm_if.sv
// Command/status bundle between the PID compensator and the DPWM power-stage driver.
interface buck_dpwm_if #(
  parameter int DUTY_W = 9
);
  logic              en;
  logic [DUTY_W-1:0] duty_in;
  logic              duty_valid;
  logic              hs_gate;
  logic              ls_gate;
  logic              period_start;
  logic              sample_trig;
  logic [DUTY_W-1:0] duty_active;

  modport master (
    output en, duty_in, duty_valid,
    input  hs_gate, ls_gate, period_start, sample_trig, duty_active
  );

  modport slave (
    input  en, duty_in, duty_valid,
    output hs_gate, ls_gate, period_start, sample_trig, duty_active
  );
endinterface

// File: rtl/buck_dpwm.sv
// Counter-based buck DPWM: double-buffered duty, complementary gates, per-period ADC trigger.
// Define DPWM_DEAD_TIME_EN to insert the dead-time FSM between gate transitions.
module buck_dpwm #(
  parameter int DUTY_W   = 9,
  parameter int DUTY_MAX = 486,
  parameter int DEAD_CYC = 4
) (
  input logic       clk,
  input logic       reset,
  buck_dpwm_if.slave bus
);
  // Never let the clamp squeeze the off-time below two dead times.
  localparam int                OFF_LIMIT  = 2**DUTY_W - 2*DEAD_CYC;
  localparam int                CLAMP_I    = (DUTY_MAX < OFF_LIMIT) ? DUTY_MAX : OFF_LIMIT;
  localparam logic [DUTY_W-1:0] DUTY_CLAMP = DUTY_W'(CLAMP_I);
  localparam logic [DUTY_W-1:0] CNT_LAST   = '1;

  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic [DUTY_W-1:0] duty_clamped;
  logic              pstart_q, pstart_d;
  logic              strig_q, strig_d;
  logic              pwm_raw;

  always_comb begin
    duty_clamped = (bus.duty_in > DUTY_CLAMP) ? DUTY_CLAMP : bus.duty_in;
    cnt_d        = bus.en ? cnt_q + 1'b1 : '0;
    shadow_d     = bus.duty_valid ? duty_clamped : shadow_q;
    active_d     = active_q;
    // A write landing on the wrap cycle bypasses the shadow.
    if (cnt_q == CNT_LAST)
      active_d = bus.duty_valid ? duty_clamped : shadow_q;
    pstart_d     = bus.en && (cnt_q == '0);
    strig_d      = bus.en && (cnt_q == (active_q >> 1));
  end

  assign pwm_raw = (cnt_q < active_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      pstart_q <= 1'b0;
      strig_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pstart_q <= pstart_d;
      strig_q  <= strig_d;
    end
  end

  assign bus.period_start = pstart_q;
  assign bus.sample_trig  = strig_q;
  assign bus.duty_active  = active_q;

`ifdef DPWM_DEAD_TIME_EN
  typedef enum logic [3:0] {
    LS_ON = 4'b0001,
    DT_LH = 4'b0010,
    HS_ON = 4'b0100,
    DT_HL = 4'b1000
  } state_t;

  localparam logic [3:0] DT_RELOAD = 4'(DEAD_CYC - 1);

  state_t     state_q;
  logic [3:0] dt_cnt_q;

  // Reset and disable both park in DT_HL so the low side waits out a full dead time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= DT_HL;
      dt_cnt_q <= DT_RELOAD;
    end else if (!bus.en) begin
      state_q  <= DT_HL;
      dt_cnt_q <= DT_RELOAD;
    end else begin
      case (state_q)
        LS_ON: if (pwm_raw) begin
          state_q  <= DT_LH;
          dt_cnt_q <= DT_RELOAD;
        end
        DT_LH: begin
          if (!pwm_raw)             state_q  <= LS_ON;
          else if (dt_cnt_q == '0)  state_q  <= HS_ON;
          else                      dt_cnt_q <= dt_cnt_q - 1'b1;
        end
        HS_ON: if (!pwm_raw) begin
          state_q  <= DT_HL;
          dt_cnt_q <= DT_RELOAD;
        end
        DT_HL: begin
          if (dt_cnt_q == '0) state_q  <= LS_ON;
          else                dt_cnt_q <= dt_cnt_q - 1'b1;
        end
        default: begin
          state_q  <= DT_HL;
          dt_cnt_q <= DT_RELOAD;
        end
      endcase
    end
  end

  assign bus.hs_gate = state_q[2];
  assign bus.ls_gate = state_q[0];
`else
  logic hs_q, hs_d;
  logic ls_q, ls_d;

  always_comb begin
    hs_d = bus.en & pwm_raw;
    ls_d = bus.en & ~pwm_raw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b0;
      ls_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      ls_q <= ls_d;
    end
  end

  assign bus.hs_gate = hs_q;
  assign bus.ls_gate = ls_q;
`endif
endmodule
